// File: rtl/core_run_sequencer_if.sv
// Program-load stream, instruction-memory write port and core control lines
// shared between the run sequencer (master) and the core/loader side (slave).
interface core_run_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  imem_w_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    logic [DATA_WIDTH-1:0] imem_wr_data;
    logic [DATA_WIDTH-1:0] instr;
    logic                  memread;
    logic                  core_flush;
    logic                  core_run;

    modport master (
        input  load_valid, load_data, instr, memread,
        output load_ready, imem_w_en, imem_wr_addr, imem_wr_data, core_flush, core_run
    );

    modport slave (
        output load_valid, load_data, instr, memread,
        input  load_ready, imem_w_en, imem_wr_addr, imem_wr_data, core_flush, core_run
    );
endinterface

// File: rtl/core_run_sequencer.sv
// Run controller for the single-cycle RV32 core: boot-loads instruction memory,
// then gates core progress with a data-read wait state, halt detection and a cycle budget.
module core_run_sequencer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [CNT_WIDTH-1:0]  MAX_CYCLES = 16'hFFFF,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h00100073
) (
    input  logic                 clk,
    input  logic                 rst,
    core_run_sequencer_if.master bus,
    input  logic                 i_start,
    input  logic [ADDR_WIDTH:0]  i_prog_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic [CNT_WIDTH-1:0] o_retired_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PREP,
        S_RUN,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST_CYCLE = MAX_CYCLES - 1'b1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_prog_len;
    logic                  r_done;
    logic                  r_timeout;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [CNT_WIDTH-1:0]  r_retired_count;

    logic                  w_is_halt;
    logic                  w_budget_hit;
    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_start_ok;
    logic                  w_run_retire;
    logic [CNT_WIDTH-1:0]  w_cycle_next;

    assign w_is_halt    = (bus.instr == HALT_INSTR);
    // ">=" lets a budget crossed during WAIT still trigger the timeout in RUN.
    assign w_budget_hit = (r_cycle_count >= LP_LAST_CYCLE);
    assign w_accept     = bus.load_valid && (r_state == S_LOAD);
    assign w_last_word  = ({1'b0, r_wr_addr} == (r_prog_len - 1'b1));
    assign w_start_ok   = i_start && (i_prog_len != '0);
    assign w_run_retire = (r_state == S_RUN) && !w_is_halt && !w_budget_hit && !bus.memread;
    assign w_cycle_next = (r_cycle_count == MAX_CYCLES) ? r_cycle_count : r_cycle_count + 1'b1;

    assign bus.load_ready   = (r_state == S_LOAD);
    assign bus.imem_w_en    = w_accept;
    assign bus.imem_wr_addr = r_wr_addr;
    assign bus.imem_wr_data = bus.load_data;
    assign bus.core_flush   = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_PREP);
    assign bus.core_run     = w_run_retire || (r_state == S_WAIT);

    assign o_busy          = (r_state == S_LOAD) || (r_state == S_PREP) ||
                             (r_state == S_RUN)  || (r_state == S_WAIT);
    assign o_done          = r_done;
    assign o_timeout       = r_timeout;
    assign o_cycle_count   = r_cycle_count;
    assign o_retired_count = r_retired_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_wr_addr       <= '0;
            r_prog_len      <= '0;
            r_done          <= 1'b0;
            r_timeout       <= 1'b0;
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= S_LOAD;
                        r_wr_addr  <= '0;
                        r_prog_len <= i_prog_len;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (w_last_word) begin
                            r_state <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    r_cycle_count   <= '0;
                    r_retired_count <= '0;
                    r_state         <= S_RUN;
                end
                S_RUN: begin
                    r_cycle_count <= w_cycle_next;
                    if (w_is_halt) begin
                        r_state <= S_HALT;
                        r_done  <= 1'b1;
                    end else if (w_budget_hit) begin
                        r_state   <= S_HALT;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (bus.memread) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_retired_count <= r_retired_count + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cycle_count   <= w_cycle_next;
                    r_retired_count <= r_retired_count + 1'b1;
                    r_state         <= S_RUN;
                end
                S_HALT: begin
                    if (w_start_ok) begin
                        r_state    <= S_LOAD;
                        r_wr_addr  <= '0;
                        r_prog_len <= i_prog_len;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_run_sequencer.sv
// Cycle-by-cycle vector bench for core_run_sequencer with a small ADDR_WIDTH and
// MAX_CYCLES so memory wrap and the cycle budget are reachable quickly.
module tb_core_run_sequencer;
    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    typedef struct packed {
        logic        rdy;
        logic        wen;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        run;
        logic        bz;
        logic        dn;
        logic        to;
        logic [15:0] cy;
        logic [15:0] rt;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        st;
        logic [3:0]  pl;
        logic        lv;
        logic [31:0] ld;
        logic [31:0] ins;
        logic        mr;
        obs_t        e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  prog_len;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [15:0] retired_count;

    int   n_compared;
    int   n_failed;
    vec_t vecs[$];
    obs_t sb[$];

    core_run_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    core_run_sequencer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3),
        .CNT_WIDTH (16),
        .MAX_CYCLES(16'd10),
        .HALT_INSTR(HALT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .i_start        (start),
        .i_prog_len     (prog_len),
        .o_busy         (busy),
        .o_done         (done),
        .o_timeout      (timeout),
        .o_cycle_count  (cycle_count),
        .o_retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mkObs(input logic rdy, input logic wen, input logic [2:0] wa,
                                   input logic [31:0] wd, input logic fl, input logic run,
                                   input logic bz, input logic dn, input logic to,
                                   input logic [15:0] cy, input logic [15:0] rt);
        obs_t o;
        o.rdy = rdy; o.wen = wen; o.wa = wa; o.wd = wd; o.fl = fl; o.run = run;
        o.bz = bz; o.dn = dn; o.to = to; o.cy = cy; o.rt = rt;
        return o;
    endfunction

    task automatic addV(input logic r, input logic st, input logic [3:0] pl, input logic lv,
                        input logic [31:0] ld, input logic [31:0] ins, input logic mr,
                        input obs_t e);
        vec_t v;
        v.rst = r; v.st = st; v.pl = pl; v.lv = lv; v.ld = ld; v.ins = ins; v.mr = mr; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic vIdle(input logic r, input logic st, input logic [3:0] pl,
                         input logic [15:0] cy, input logic [15:0] rt);
        addV(r, st, pl, 1'b0, 32'h0, NOP, 1'b0,
             mkObs(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cy, rt));
    endtask

    // Load vectors drive a stray prog_len of 2 to show only the value seen at start matters.
    task automatic vLoad(input logic r, input logic lv, input logic [31:0] ld, input logic [2:0] wa,
                         input logic [15:0] cy, input logic [15:0] rt);
        addV(r, 1'b0, 4'd2, lv, ld, NOP, 1'b0,
             mkObs(1'b1, lv, wa, ld, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cy, rt));
    endtask

    task automatic vPrep(input logic [15:0] cy, input logic [15:0] rt);
        addV(1'b0, 1'b0, 4'd0, 1'b1, 32'hDEAD_0000, NOP, 1'b0,
             mkObs(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cy, rt));
    endtask

    task automatic vRun(input logic r, input logic st, input logic [31:0] ins, input logic mr,
                        input logic run, input logic [15:0] cy, input logic [15:0] rt);
        addV(r, st, 4'd1, 1'b0, 32'h0, ins, mr,
             mkObs(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, run, 1'b1, 1'b0, 1'b0, cy, rt));
    endtask

    task automatic vHalt(input logic st, input logic [3:0] pl, input logic to,
                         input logic [15:0] cy, input logic [15:0] rt);
        addV(1'b0, st, pl, 1'b0, 32'h0, NOP, 1'b0,
             mkObs(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, to, cy, rt));
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        start          = v.st;
        prog_len       = v.pl;
        bus.load_valid = v.lv;
        bus.load_data  = v.ld;
        bus.instr      = v.ins;
        bus.memread    = v.mr;
        sb.push_back(v.e);
    endtask

    task automatic checkOutput(input string nm);
        obs_t exp_o;
        obs_t act;
        n_compared++;
        if (sb.size() == 0) begin
            n_failed++;
            $display("[TB] FAIL %s: scoreboard empty, nothing to compare against", nm);
            return;
        end
        exp_o = sb.pop_front();
        act   = mkObs(bus.load_ready, bus.imem_w_en, bus.imem_wr_addr, bus.imem_wr_data,
                      bus.core_flush, bus.core_run, busy, done, timeout, cycle_count, retired_count);
        if (!exp_o.wen) begin
            act.wa = '0; act.wd = '0; exp_o.wa = '0; exp_o.wd = '0;
        end
        if (act !== exp_o) begin
            n_failed++;
            $display("[TB] FAIL %s: actual rdy=%b wen=%b wa=%0d wd=%h fl=%b run=%b bz=%b dn=%b to=%b cy=%0d rt=%0d | required rdy=%b wen=%b wa=%0d wd=%h fl=%b run=%b bz=%b dn=%b to=%b cy=%0d rt=%0d",
                     nm, act.rdy, act.wen, act.wa, act.wd, act.fl, act.run, act.bz, act.dn, act.to, act.cy, act.rt,
                     exp_o.rdy, exp_o.wen, exp_o.wa, exp_o.wd, exp_o.fl, exp_o.run, exp_o.bz, exp_o.dn, exp_o.to, exp_o.cy, exp_o.rt);
        end
    endtask

    initial begin
        n_compared     = 0;
        n_failed       = 0;
        rst            = 1'b1;
        start          = 1'b0;
        prog_len       = 4'd0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'h0;
        bus.instr      = NOP;
        bus.memread    = 1'b0;

        // Reset, start with zero length, 5-word load, 4 instructions then halt
        vIdle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        vIdle(1'b0, 1'b1, 4'd0, 16'd0, 16'd0);
        vIdle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        vIdle(1'b0, 1'b1, 4'd5, 16'd0, 16'd0);
        for (int i = 0; i < 5; i++) vLoad(1'b0, 1'b1, 32'hA000_0000 + i, 3'(i), 16'd0, 16'd0);
        vPrep(16'd0, 16'd0);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd0, 16'd0);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd1, 16'd1);
        vRun(1'b0, 1'b1, NOP, 1'b0, 1'b1, 16'd2, 16'd2);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd3, 16'd3);
        vRun(1'b0, 1'b0, HALT, 1'b0, 1'b0, 16'd4, 16'd4);
        vHalt(1'b0, 4'd0, 1'b0, 16'd5, 16'd4);
        vHalt(1'b0, 4'd0, 1'b0, 16'd5, 16'd4);

        // Toggling load_valid over 3 words, then a memread wait state
        vHalt(1'b1, 4'd3, 1'b0, 16'd5, 16'd4);
        vLoad(1'b0, 1'b1, 32'hB000_0000, 3'd0, 16'd5, 16'd4);
        vLoad(1'b0, 1'b0, 32'hBAD0_0001, 3'd1, 16'd5, 16'd4);
        vLoad(1'b0, 1'b1, 32'hB000_0001, 3'd1, 16'd5, 16'd4);
        vLoad(1'b0, 1'b0, 32'hBAD0_0002, 3'd2, 16'd5, 16'd4);
        vLoad(1'b0, 1'b1, 32'hB000_0002, 3'd2, 16'd5, 16'd4);
        vPrep(16'd5, 16'd4);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd0, 16'd0);
        vRun(1'b0, 1'b0, NOP, 1'b1, 1'b0, 16'd1, 16'd1);
        vRun(1'b0, 1'b0, NOP, 1'b1, 1'b1, 16'd2, 16'd1);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd3, 16'd2);
        vRun(1'b0, 1'b0, HALT, 1'b0, 1'b0, 16'd4, 16'd3);
        vHalt(1'b0, 4'd0, 1'b0, 16'd5, 16'd3);

        // Budget of 10 cycles with no halt instruction
        vHalt(1'b1, 4'd1, 1'b0, 16'd5, 16'd3);
        vLoad(1'b0, 1'b1, 32'hC000_0000, 3'd0, 16'd5, 16'd3);
        vPrep(16'd5, 16'd3);
        for (int k = 0; k < 10; k++) vRun(1'b0, 1'b0, NOP, 1'b0, (k < 9), 16'(k), 16'(k));
        vHalt(1'b0, 4'd0, 1'b1, 16'd10, 16'd9);

        // Budget crossed inside WAIT: instruction retires, next RUN cycle times out
        vHalt(1'b1, 4'd1, 1'b1, 16'd10, 16'd9);
        vLoad(1'b0, 1'b0, 32'hC100_0000, 3'd0, 16'd10, 16'd9);
        vLoad(1'b0, 1'b1, 32'hC100_0001, 3'd0, 16'd10, 16'd9);
        vPrep(16'd10, 16'd9);
        for (int k = 0; k < 8; k++) vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'(k), 16'(k));
        vRun(1'b0, 1'b0, NOP, 1'b1, 1'b0, 16'd8, 16'd8);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd9, 16'd8);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b0, 16'd10, 16'd9);
        vHalt(1'b0, 4'd0, 1'b1, 16'd10, 16'd9);

        // Reset mid-LOAD and mid-RUN
        vHalt(1'b1, 4'd4, 1'b1, 16'd10, 16'd9);
        vLoad(1'b0, 1'b1, 32'hD000_0000, 3'd0, 16'd10, 16'd9);
        vLoad(1'b0, 1'b1, 32'hD000_0001, 3'd1, 16'd10, 16'd9);
        vLoad(1'b1, 1'b1, 32'hD000_0002, 3'd2, 16'd10, 16'd9);
        vIdle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        vIdle(1'b0, 1'b1, 4'd1, 16'd0, 16'd0);
        vLoad(1'b0, 1'b1, 32'hE000_0000, 3'd0, 16'd0, 16'd0);
        vPrep(16'd0, 16'd0);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd0, 16'd0);
        vRun(1'b0, 1'b0, NOP, 1'b0, 1'b1, 16'd1, 16'd1);
        vRun(1'b1, 1'b0, NOP, 1'b0, 1'b1, 16'd2, 16'd2);
        vIdle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);

        // Full-memory load of 8 words, then halt on the very first fetch
        vIdle(1'b0, 1'b1, 4'd8, 16'd0, 16'd0);
        for (int i = 0; i < 8; i++) vLoad(1'b0, 1'b1, 32'hF000_0000 + i, 3'(i), 16'd0, 16'd0);
        vPrep(16'd0, 16'd0);
        vRun(1'b0, 1'b0, HALT, 1'b0, 1'b0, 16'd0, 16'd0);
        vHalt(1'b0, 4'd0, 1'b0, 16'd1, 16'd0);

        repeat (2) @(negedge clk);
        sb.push_back(mkObs(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        #1;
        checkOutput("reset_state");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i));
        end

        // Reset held for two cycles out of HALT clears sticky done and the counters
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(mkObs(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        #1;
        checkOutput("rst_from_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
